// File: rtl/imem_load_ctrl.sv
`default_nettype none
// ============================================================================
// imem_load_ctrl : byte-serial program loader for the instruction memory
// Revision 1.0
// ============================================================================
module imem_load_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [9:0]        load_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              cpu_run,
  output logic              load_done,
  output logic [9:0]        words_loaded,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_wea,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_RUN   = 2'd3;

  localparam logic [9:0] MAX_LEN = 10'(1 << ADDR_W);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [9:0]        len;
  logic [1:0]        byte_cnt;
  logic [DATA_W-1:0] asm_word;
  logic [9:0]        len_clamp;
  logic [9:0]        words_inc;
  logic              start_acc;
  logic              byte_acc;

  assign len_clamp = (load_len > MAX_LEN) ? MAX_LEN : load_len;
  assign words_inc = words_loaded + 10'd1;
  assign start_acc = load_start && ((state == ST_IDLE) || (state == ST_RUN));
  assign byte_acc  = ld_valid && (state == ST_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_RUN: begin
        if (start_acc) begin
          state_nxt = (len_clamp == 10'd0) ? ST_RUN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (byte_acc && (byte_cnt == 2'd3)) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_nxt = (words_inc == len) ? ST_RUN : ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_run  = (state == ST_RUN);
    ld_ready = (state == ST_LOAD);
    mem_wea  = (state == ST_WRITE);
    mem_din  = asm_word;
    // The write counter owns the address only while a word is being committed.
    mem_addr = (state == ST_WRITE) ? words_loaded[ADDR_W-1:0] : if_addr;
    if_data  = (state == ST_RUN) ? mem_dout : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len          <= '0;
      byte_cnt     <= '0;
      asm_word     <= '0;
      words_loaded <= '0;
      load_done    <= 1'b0;
    end else begin
      load_done <= (start_acc && (len_clamp == 10'd0)) ||
                   ((state == ST_WRITE) && (words_inc == len));
      if (start_acc) begin
        len          <= len_clamp;
        byte_cnt     <= '0;
        words_loaded <= '0;
      end else if (byte_acc) begin
        asm_word[{byte_cnt, 3'b000} +: 8] <= ld_data;
        byte_cnt                          <= byte_cnt + 2'd1;
      end else if (state == ST_WRITE) begin
        words_loaded <= words_inc;
      end
    end
  end

endmodule
`default_nettype wire
